// File: rtl/sump_pkg.sv
// Shared constants for the SUMP command controller: opcodes, FSM states, ID word.
package sump_pkg;

   localparam logic [31:0] IdWordDefault = 32'h31414C53;

   localparam logic [7:0] OpReset   = 8'h00;
   localparam logic [7:0] OpArm     = 8'h01;
   localparam logic [7:0] OpMeta    = 8'h02;
   localparam logic [7:0] OpId      = 8'h04;
   localparam logic [7:0] OpDivider = 8'h80;
   localparam logic [7:0] OpCount   = 8'h81;
   localparam logic [7:0] OpTrigger = 8'hC1;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StExec
   } ctrl_state_e;

endpackage

// File: rtl/sump_id_tx.sv
// Four-byte ID shifter with a valid/ready transmit handshake; abort beats start and consume.
module sump_id_tx
   import sump_pkg::*;
#(
   parameter logic [31:0] ID_WORD = IdWordDefault
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       abort_i,
   output logic       busy_o,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   input  logic       tx_ready_i
);

   logic        busy_q, busy_d;
   logic [31:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q  <= 1'b0;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         busy_q  <= busy_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   // A start while busy is dropped here, so the controller never has to check.
   always_comb begin
      busy_d  = busy_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (abort_i) begin
         busy_d  = 1'b0;
         shift_d = '0;
         cnt_d   = '0;
      end else if (busy_q) begin
         if (tx_ready_i) begin
            shift_d = {shift_q[23:0], 8'h00};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               busy_d = 1'b0;
            end
         end
      end else if (start_i) begin
         busy_d  = 1'b1;
         shift_d = ID_WORD;
         cnt_d   = '0;
      end
   end

   assign busy_o     = busy_q;
   assign tx_valid_o = busy_q;
   assign tx_data_o  = busy_q ? shift_q[31:24] : 8'h00;

endmodule

// File: rtl/sump_cmd_ctrl.sv
// SUMP 5-byte command decoder with configuration registers and ID reply.
// Optional byte timeout in COLLECT is enabled by defining SUMP_BYTE_TIMEOUT_EN.
module sump_cmd_ctrl
   import sump_pkg::*;
#(
   parameter int unsigned BYTE_TIMEOUT_CYC = 100000,
   parameter logic [31:0] ID_WORD          = IdWordDefault
) (
   input  logic        system_clock,
   input  logic        ext_reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        cmd_reset,
   output logic        cmd_arm,
   output logic        cmd_meta,
   output logic        cmd_error,
   output logic [23:0] divider,
   output logic [15:0] read_count,
   output logic [15:0] delay_count,
   output logic [7:0]  trig_rise,
   output logic [7:0]  trig_fall
);

   ctrl_state_e state_q, state_d;
   logic [2:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [23:0] param_q, param_d;

   logic        cmd_reset_q, cmd_reset_d;
   logic        cmd_arm_q, cmd_arm_d;
   logic        cmd_meta_q, cmd_meta_d;
   logic        cmd_error_q, cmd_error_d;
   logic [23:0] divider_q, divider_d;
   logic [15:0] read_count_q, read_count_d;
   logic [15:0] delay_count_q, delay_count_d;
   logic [7:0]  trig_rise_q, trig_rise_d;
   logic [7:0]  trig_fall_q, trig_fall_d;

   logic        frame_done;
   logic [31:0] frame_word;
   logic        timeout_hit;
   logic        id_start;
   logic        id_abort;
   logic        id_busy;

   // Decode happens on the edge that accepts byte 5, so results show during EXEC.
   assign frame_done = (state_q == StCollect) && rx_valid && (byte_cnt_q == 3'd3);
   assign frame_word = {param_q, rx_data};

`ifdef SUMP_BYTE_TIMEOUT_EN
   localparam int unsigned TimeoutW = $clog2(BYTE_TIMEOUT_CYC + 1);

   logic [TimeoutW-1:0] timeout_q, timeout_d;

   assign timeout_hit = (state_q == StCollect) && !rx_valid &&
                        (timeout_q == TimeoutW'(BYTE_TIMEOUT_CYC - 1));

   always_comb begin
      timeout_d = '0;
      if ((state_q == StCollect) && !rx_valid && !timeout_hit) begin
         timeout_d = timeout_q + TimeoutW'(1);
      end
   end

   always_ff @(posedge system_clock or negedge ext_reset_n) begin
      if (!ext_reset_n) begin
         timeout_q <= '0;
      end else begin
         timeout_q <= timeout_d;
      end
   end
`else
   logic unused_timeout_cyc;

   assign unused_timeout_cyc = ^BYTE_TIMEOUT_CYC;
   assign timeout_hit        = 1'b0;
`endif

   always_ff @(posedge system_clock or negedge ext_reset_n) begin
      if (!ext_reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (rx_valid) begin
               state_d = StCollect;
            end
         end
         StCollect: begin
            if (rx_valid) begin
               if (byte_cnt_q == 3'd3) begin
                  state_d = StExec;
               end
            end else if (timeout_hit) begin
               state_d = StIdle;
            end
         end
         StExec:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Frame assembly: opcode latched in IDLE, first three params shifted in.
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      opcode_d   = opcode_q;
      param_d    = param_q;
      unique case (state_q)
         StIdle: begin
            byte_cnt_d = 3'd0;
            if (rx_valid) begin
               opcode_d = rx_data;
            end
         end
         StCollect: begin
            if (rx_valid) begin
               byte_cnt_d = byte_cnt_q + 3'd1;
               param_d    = {param_q[15:0], rx_data};
            end else if (timeout_hit) begin
               byte_cnt_d = 3'd0;
            end
         end
         default: byte_cnt_d = 3'd0;
      endcase
   end

   always_comb begin
      cmd_reset_d   = 1'b0;
      cmd_arm_d     = 1'b0;
      cmd_meta_d    = 1'b0;
      cmd_error_d   = 1'b0;
      id_start      = 1'b0;
      id_abort      = 1'b0;
      divider_d     = divider_q;
      read_count_d  = read_count_q;
      delay_count_d = delay_count_q;
      trig_rise_d   = trig_rise_q;
      trig_fall_d   = trig_fall_q;
      if (frame_done) begin
         case (opcode_q)
            OpReset: begin
               cmd_reset_d   = 1'b1;
               id_abort      = 1'b1;
               divider_d     = '0;
               read_count_d  = '0;
               delay_count_d = '0;
               trig_rise_d   = '0;
               trig_fall_d   = '0;
            end
            OpArm:  cmd_arm_d  = 1'b1;
            OpMeta: cmd_meta_d = 1'b1;
            OpId:   id_start   = 1'b1;
            OpDivider: divider_d = frame_word[23:0];
            OpCount: begin
               read_count_d  = frame_word[31:16];
               delay_count_d = frame_word[15:0];
            end
            OpTrigger: begin
               trig_fall_d = frame_word[15:8];
               trig_rise_d = frame_word[7:0];
            end
            default: cmd_error_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge system_clock or negedge ext_reset_n) begin
      if (!ext_reset_n) begin
         byte_cnt_q    <= '0;
         opcode_q      <= '0;
         param_q       <= '0;
         cmd_reset_q   <= 1'b0;
         cmd_arm_q     <= 1'b0;
         cmd_meta_q    <= 1'b0;
         cmd_error_q   <= 1'b0;
         divider_q     <= '0;
         read_count_q  <= '0;
         delay_count_q <= '0;
         trig_rise_q   <= '0;
         trig_fall_q   <= '0;
      end else begin
         byte_cnt_q    <= byte_cnt_d;
         opcode_q      <= opcode_d;
         param_q       <= param_d;
         cmd_reset_q   <= cmd_reset_d;
         cmd_arm_q     <= cmd_arm_d;
         cmd_meta_q    <= cmd_meta_d;
         cmd_error_q   <= cmd_error_d;
         divider_q     <= divider_d;
         read_count_q  <= read_count_d;
         delay_count_q <= delay_count_d;
         trig_rise_q   <= trig_rise_d;
         trig_fall_q   <= trig_fall_d;
      end
   end

   sump_id_tx #(
      .ID_WORD(ID_WORD)
   ) u_id_tx (
      .clk_i      (system_clock),
      .rst_ni     (ext_reset_n),
      .start_i    (id_start),
      .abort_i    (id_abort),
      .busy_o     (id_busy),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .tx_ready_i (tx_ready)
   );

   logic unused_id_busy;

   assign unused_id_busy = id_busy;

   assign cmd_reset   = cmd_reset_q;
   assign cmd_arm     = cmd_arm_q;
   assign cmd_meta    = cmd_meta_q;
   assign cmd_error   = cmd_error_q;
   assign divider     = divider_q;
   assign read_count  = read_count_q;
   assign delay_count = delay_count_q;
   assign trig_rise   = trig_rise_q;
   assign trig_fall   = trig_fall_q;

endmodule

// File: doc/sump_cmd_ctrl.md
SUMP_CMD_CTRL -- requirements
Module: sump_cmd_ctrl

Interface
REQ-001 SHALL have parameter BYTE_TIMEOUT_CYC, default 100000: idle cycles between frame bytes before framing resynchronises.
REQ-002 SHALL have parameter ID_WORD, default 32'h31414C53: identification bytes, sent MSB first ("1ALS").
REQ-003 SHALL have port system_clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port ext_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports rx_data  input  8  and rx_valid  input  1  UART receive byte and its one-cycle strobe.
REQ-006 SHALL have ports tx_data  output  8, tx_valid  output  1 and tx_ready  input  1  UART transmit handshake.
REQ-007 SHALL have ports cmd_reset, cmd_arm, cmd_meta, cmd_error  output  1 each  one-cycle command strobes.
REQ-008 SHALL have ports divider  output  24, read_count  output  16, delay_count  output  16, trig_rise  output  8, trig_fall  output  8  configuration registers.

Function
REQ-009 SHALL frame every command as 5 bytes: opcode, then P1..P4, parameter word W = {P1,P2,P3,P4}.
REQ-010 SHALL use FSM IDLE -> COLLECT (byte count 1..4) -> EXEC (one cycle) -> IDLE; IDLE leaves on rx_valid, latching the opcode.
REQ-011 SHALL assert the decoded strobe or register update in the cycle after the rx_valid of byte 5 (latency 1 cycle); EXEC ignores rx_valid.
REQ-012 SHALL decode 0x00 -> cmd_reset, 0x01 -> cmd_arm, 0x02 -> cmd_meta, 0x04 -> start ID transmission.
REQ-013 SHALL decode 0x80 -> divider = W[23:0]; 0x81 -> read_count = W[31:16], delay_count = W[15:0]; 0xC1 -> trig_fall = W[15:8], trig_rise = W[7:0].
REQ-014 SHALL pulse cmd_error for any other opcode, changing no register.
REQ-015 SHALL, on opcode 0x00, also return every configuration register to its reset value and abort any ID transmission (tx_valid low next cycle).
REQ-016 SHALL hold tx_data stable and tx_valid high until a cycle with tx_ready high; the byte is consumed on that edge, and the next byte is presented the following cycle.
REQ-017 SHALL ignore opcode 0x04 while an ID transmission is in progress (no restart, no cmd_error).
REQ-018 SHALL accept frames concurrently with ID transmission.

Reset
REQ-019 SHALL, while ext_reset_n is low, force FSM to IDLE, byte count 0, all strobes 0, tx_valid 0, tx_data 0x00, divider/read_count/delay_count/trig_rise/trig_fall 0.
REQ-020 SHALL discard any partial frame or transmission when reset asserts mid-operation, and resume in IDLE on the first edge after release.

Configuration
REQ-021 SHALL, with macro SUMP_BYTE_TIMEOUT_EN defined, return COLLECT to IDLE after BYTE_TIMEOUT_CYC cycles without rx_valid, discarding the partial frame silently.
REQ-022 SHALL give rx_valid priority over timeout expiry in the same cycle (byte accepted, counter cleared).
REQ-023 SHALL, without SUMP_BYTE_TIMEOUT_EN, contain no timeout counter; COLLECT waits indefinitely.

Structure
REQ-024 SHALL take opcode constants, FSM state enum and ID_WORD default from shared package sump_pkg.
REQ-025 SHALL implement ID transmission in sub-module sump_id_tx: 4-byte shifter with tx handshake, start and abort inputs, busy output.

Verification
REQ-026 SHALL verify: five 0x00 frames -> exactly one cmd_reset pulse per frame, all registers 0.
REQ-027 SHALL verify: 80 00 0F 42 3F -> divider = 24'h0F423F one cycle after byte 5.
REQ-028 SHALL verify: 81 12 34 56 78 -> read_count = 16'h1234, delay_count = 16'h5678; C1 00 00 AA 55 -> trig_fall = 8'hAA, trig_rise = 8'h55.
REQ-029 SHALL verify: 04 00 00 00 00 with tx_ready low for 10 cycles, then high -> tx_data held at 0x31, then 0x31, 0x41, 0x4C, 0x53 in order.
REQ-030 SHALL verify: opcode 0x7E frame -> single cmd_error pulse, registers unchanged.
REQ-031 SHALL verify, with SUMP_BYTE_TIMEOUT_EN: 80 01, then gap > BYTE_TIMEOUT_CYC, then 01 00 00 00 00 -> cmd_arm pulse, divider unchanged.
